forwarding_hazard_unit: RTL
===========================

Name: forwarding_hazard_unit

Overview:
Generates registered one-hot select triples for the EX-stage operand-A and operand-B 3-to-1 forwarding multiplexers, which are the downstream consumers. Per operand, exactly one source is chosen: register file, EX/MEM result, or MEM/WB result. The block keeps its own shadow pipeline of destination/write/load tags for the EX, MEM and WB stages. It detects load-use hazards and emits a one-cycle stall; it also absorbs branch flushes.

Parameters:
REG_ADDR_W, 5, register-address width.
ZERO_REG_HARDWIRED, 1, when 1, register 0 is never forwarded and never causes a stall.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decode-stage instruction is valid
id_rs  in  REG_ADDR_W  decode source register A
id_rt  in  REG_ADDR_W  decode source register B
id_uses_rs  in  1  instruction reads rs
id_uses_rt  in  1  instruction reads rt
id_rd  in  REG_ADDR_W  decode destination register
id_reg_write  in  1  instruction writes rd
id_mem_read  in  1  instruction is a load
ex_flush  in  1  branch taken in EX; kill the instruction in ID
stall  out  1  hold PC and IF/ID; combinational from state and ID inputs
fwd_a_sel  out  3  one-hot select for operand A: {memwb, exmem, reg}
fwd_b_sel  out  3  one-hot select for operand B: same encoding

Behaviour:
- Reset (asynchronous, any time, including mid-stall): all shadow valid/write/load bits are 0, fwd_a_sel = fwd_b_sel = 3'b001, stall = 0. Rd tags are don't-care.
- Shadow stages: ex, mem, wb. Each holds rd, we, load, valid.
- Every clock: wb <= mem, and mem <= ex.
- ex input selection:
  - ex <= ID fields when id_valid && !stall && !ex_flush.
  - Otherwise ex <= bubble (valid = 0, we = 0, load = 0).
- Effective producer write: we && valid && !(ZERO_REG_HARDWIRED && rd == 0).
- Load-use stall:
  - stall = id_valid && !ex_flush && ex.load && ex.effective_we && ((id_uses_rs && id_rs == ex.rd) || (id_uses_rt && id_rt == ex.rd)).
  - Stall lasts exactly one cycle. Next cycle the load sits in mem, so the re-presented consumer forwards from MEM/WB.
- Forwarding selects are registered and aligned with the instruction entering EX. Per operand, on the clock edge that loads ex:
  - if the operand is used and matches ex.rd with ex.effective_we (and ex.load is 0; a load case always stalls): select 3'b010 (EX/MEM), the newest data.
  - else if it matches mem.rd with mem.effective_we: select 3'b100 (MEM/WB).
  - else select 3'b001 (register file).
- When a bubble is inserted (stall, flush or !id_valid), both selects load 3'b001.
- Outputs are always exactly one-hot: never 000 and never multi-hot. The downstream mux holds its value when no select is set, so 000 is forbidden.
- A producer already in WB is not forwarded. The register file is write-before-read within a cycle.
- Stall and ex_flush in the same cycle: flush wins, stall = 0, and a bubble enters ex.
- Latency: a select takes effect 1 cycle after the consumer is presented in ID (no stall), or 2 cycles (with stall).

Optional Feature:
STALL_COUNT_EN
- Defined: adds an output stall_count (16 bits). It resets to 0, increments on every cycle with stall = 1, and saturates at 16'hFFFF.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- Package fwd_pkg holds:
  - the localparams FWD_REG = 3'b001, FWD_EXMEM = 3'b010, FWD_MEMWB = 3'b100;
  - the typedef fwd_sel_t (logic [2:0]);
  - the struct stage_tag_t {rd, we, load, valid}, parameterised via a package REG_ADDR_W default.
- Sub-module fwd_select: combinational next-select for one operand, taking the operand address, its use bit, and the ex and mem tags. It is instantiated twice, for A and B.

Test Plan:
- Reset: assert rst_n=0 mid-stall -> immediately stall=0, fwd_a_sel=fwd_b_sel=001; after release the first instruction with no deps gets 001/001.
- EX forward: "add r3" followed by "sub rs=r3, rt=r4" -> one cycle after sub is in ID, fwd_a_sel=010 and fwd_b_sel=001.
- Priority: "add r5; add r5; or rs=r5" -> or gets fwd_a_sel=010 (newest), not 100. With one independent instruction between, or gets 100.
- Load-use: "lw r7" then "and rt=r7" -> stall=1 for exactly one cycle, a bubble is inserted with selects 001, then and gets fwd_b_sel=100. Without STALL_COUNT_EN nothing else changes; with it, stall_count reads 1.
- Flush: raise ex_flush in the same cycle a load-use stall would occur -> stall=0, selects 001, and the next instruction sees no forward from the killed ID instruction.
- Register 0: "add r0" then "use r0" with ZERO_REG_HARDWIRED=1 -> 001 and no stall. With ZERO_REG_HARDWIRED=0 -> 010.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types for the forwarding/hazard unit: one-hot mux selects and the
// per-stage shadow tag carried down the EX/MEM pipeline.
package fwd_pkg;

    localparam int unsigned REG_ADDR_W_DEFAULT = 5;

    typedef logic [2:0] fwd_sel_t;

    // One-hot select encoding {memwb, exmem, reg}
    localparam fwd_sel_t FWD_REG   = 3'b001;
    localparam fwd_sel_t FWD_EXMEM = 3'b010;
    localparam fwd_sel_t FWD_MEMWB = 3'b100;

    typedef struct packed {
        logic [REG_ADDR_W_DEFAULT-1:0] rd;
        logic                          we;
        logic                          load;
        logic                          valid;
    } stage_tag_t;

    // A producer only counts if it is live, writes, and does not target a hardwired r0
    function automatic logic eff_we(input stage_tag_t t, input logic zero_hw);
        return t.we && t.valid && !(zero_hw && (t.rd == '0));
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Next-cycle one-hot forwarding select for a single EX operand.
module fwd_select
    import fwd_pkg::*;
#(
    parameter int unsigned REG_ADDR_W         = REG_ADDR_W_DEFAULT,
    parameter bit          ZERO_REG_HARDWIRED = 1'b1
) (
    input  logic [REG_ADDR_W-1:0] addr,
    input  logic                  uses,
    input  stage_tag_t            ex_tag,
    input  stage_tag_t            mem_tag,
    output fwd_sel_t              sel
);

    // Newest producer wins; a matching load in EX never reaches here unstalled
    always_comb begin
        sel = FWD_REG;
        if (uses && eff_we(ex_tag, ZERO_REG_HARDWIRED) && !ex_tag.load && (addr == ex_tag.rd)) begin
            sel = FWD_EXMEM;
        end else if (uses && eff_we(mem_tag, ZERO_REG_HARDWIRED) && (addr == mem_tag.rd)) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Forwarding and load-use hazard unit. Tracks shadow EX/MEM tags, produces
// registered one-hot operand selects and a combinational one-cycle stall.
// Optional macro STALL_COUNT_EN adds a saturating 16-bit stall_count output.
module forwarding_hazard_unit
    import fwd_pkg::*;
#(
    parameter int unsigned REG_ADDR_W         = REG_ADDR_W_DEFAULT,
    parameter bit          ZERO_REG_HARDWIRED = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  ex_flush,
    output logic                  stall,
    output fwd_sel_t              fwd_a_sel,
    output fwd_sel_t              fwd_b_sel
`ifdef STALL_COUNT_EN
    ,
    output logic [15:0]           stall_count
`endif
);

    // A WB-stage tag is never consulted: the register file is write-before-read,
    // so producers in WB are served by the plain register read.
    stage_tag_t ex_q;
    stage_tag_t mem_q;
    fwd_sel_t   a_next;
    fwd_sel_t   b_next;
    logic       issue;

    // Load-use detection against the instruction currently in EX; flush overrides
    always_comb begin
        stall = 1'b0;
        if (id_valid && !ex_flush && ex_q.load && eff_we(ex_q, ZERO_REG_HARDWIRED)) begin
            stall = (id_uses_rs && (id_rs == ex_q.rd)) || (id_uses_rt && (id_rt == ex_q.rd));
        end
        issue = id_valid && !stall && !ex_flush;
    end

    fwd_select #(
        .REG_ADDR_W         (REG_ADDR_W),
        .ZERO_REG_HARDWIRED (ZERO_REG_HARDWIRED)
    ) u_sel_a (
        .addr    (id_rs),
        .uses    (id_uses_rs),
        .ex_tag  (ex_q),
        .mem_tag (mem_q),
        .sel     (a_next)
    );

    fwd_select #(
        .REG_ADDR_W         (REG_ADDR_W),
        .ZERO_REG_HARDWIRED (ZERO_REG_HARDWIRED)
    ) u_sel_b (
        .addr    (id_rt),
        .uses    (id_uses_rt),
        .ex_tag  (ex_q),
        .mem_tag (mem_q),
        .sel     (b_next)
    );

    // Advance shadow pipeline; selects travel with the instruction entering EX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= '0;
            mem_q     <= '0;
            fwd_a_sel <= FWD_REG;
            fwd_b_sel <= FWD_REG;
        end else begin
            mem_q <= ex_q;
            if (issue) begin
                ex_q.rd    <= id_rd;
                ex_q.we    <= id_reg_write;
                ex_q.load  <= id_mem_read;
                ex_q.valid <= 1'b1;
                fwd_a_sel  <= a_next;
                fwd_b_sel  <= b_next;
            end else begin
                ex_q      <= '0;
                fwd_a_sel <= FWD_REG;
                fwd_b_sel <= FWD_REG;
            end
        end
    end

`ifdef STALL_COUNT_EN
    // Saturating count of stalled cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule
